// File: rtl/mp8_io_port.sv
// MP-8 outside-world I/O port: FWFT output FIFO drained over valid/ready, plus a held input byte.
// Optional MP8_IO_LOOPBACK_EN adds a loopback port that routes popped FIFO bytes straight to in_to_mp.
module mp8_io_port #(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          reset,
`ifdef MP8_IO_LOOPBACK_EN
  input  logic          loopback,
`endif
  input  logic          out_write,
  input  logic [7:0]    out_data,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [7:0]    in_to_mp,
  output logic [PW:0]   tx_count,
  output logic          overflow
);

  logic lb;
`ifdef MP8_IO_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          rx_en, empty, full, push, pop;

  assign empty    = (tx_count == '0);
  assign full     = (tx_count == (PW+1)'(DEPTH));
  assign tx_data  = mem[rd_ptr];
  assign tx_valid = !empty && !lb;
  assign rx_ready = rx_en && !lb;
  // In loopback the FIFO drains itself one byte per cycle into in_to_mp.
  assign pop      = lb ? !empty : (tx_valid && tx_ready);
  assign push     = out_write && (!full || pop);

  // Storage needs no reset; entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= out_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tx_count <= '0;
      overflow <= 1'b0;
      in_to_mp <= 8'h00;
      rx_en    <= 1'b0;
    end else begin
      rx_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: ;
      endcase
      if (out_write && !push) overflow <= 1'b1;
      if (lb && pop)
        in_to_mp <= tx_data;
      else if (rx_valid && rx_ready)
        in_to_mp <= rx_data;
    end
  end

endmodule

// File: tb/tb_mp8_io_port.sv
// Bench for mp8_io_port: directed plan then random traffic, checked each cycle against a queue-based model.
module tb_mp8_io_port;
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          out_write = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0]    out_data = 8'h00, rx_data = 8'h00;
  logic [7:0]    tx_data, in_to_mp;
  logic          tx_valid, rx_ready, overflow;
  logic [PW:0]   tx_count;
  logic          lb_eff;
`ifdef MP8_IO_LOOPBACK_EN
  logic          loopback = 1'b0;
  assign lb_eff = loopback;
`else
  assign lb_eff = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mp8_io_port #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk(clk), .reset(reset),
`ifdef MP8_IO_LOOPBACK_EN
    .loopback(loopback),
`endif
    .out_write(out_write), .out_data(out_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .in_to_mp(in_to_mp), .tx_count(tx_count), .overflow(overflow)
  );

  // Reference model: a plain byte queue plus sticky flag and held input byte.
  logic [7:0] m_q[$];
  bit         m_ovf = 1'b0;
  bit         m_rdy = 1'b0;
  logic [7:0] m_in  = 8'h00;
  bit         m_pop;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_rdy = 1'b0;
      m_in  = 8'h00;
    end else begin
      m_pop = (m_q.size() != 0) && (lb_eff || tx_ready);
      if (lb_eff && m_pop) m_in = m_q[0];
      else if (rx_valid && m_rdy && !lb_eff) m_in = rx_data;
      if (m_pop) void'(m_q.pop_front());
      if (out_write) begin
        if (m_q.size() < DEPTH) m_q.push_back(out_data);
        else m_ovf = 1'b1;
      end
      m_rdy = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every DUT output against the model away from the active edge.
  always @(negedge clk) begin
    chk("tx_valid", 32'(tx_valid), 32'((m_q.size() != 0) && !lb_eff));
    chk("tx_count", 32'(tx_count), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rx_ready", 32'(rx_ready), 32'(m_rdy && !lb_eff));
    chk("in_to_mp", 32'(in_to_mp), 32'(m_in));
    if (tx_valid && m_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    out_write = 1'b0;
    rx_valid  = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    out_write = 1'b1;
    out_data  = b;
    cyc();
    out_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) begin
      out_write = 1'($urandom);
      out_data  = 8'($urandom);
      tx_ready  = 1'($urandom);
      rx_valid  = 1'($urandom);
      rx_data   = 8'($urandom);
      cyc();
    end
    idle();
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    #1;
    do_reset();
    cyc();

    // Ordering through the FIFO
    tx_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33);
    cyc();
    tx_ready = 1'b1;
    repeat (4) cyc();

    // Overflow: fifth push into a full FIFO is dropped
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'(i));
    cyc();
    tx_ready = 1'b1;
    repeat (5) cyc();

    // Full with simultaneous push and pop
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    tx_ready = 1'b1;
    push(8'hB0);
    repeat (5) cyc();

    // Input path
    rx_valid = 1'b1; rx_data = 8'h5A;
    cyc();
    rx_valid = 1'b0; rx_data = 8'hFF;
    repeat (3) cyc();
    rx_valid = 1'b1; rx_data = 8'hC3;
    cyc();
    rx_valid = 1'b0;
    repeat (2) cyc();

`ifdef MP8_IO_LOOPBACK_EN
    loopback = 1'b1;
    tx_ready = 1'b0;
    push(8'h7E); push(8'h81);
    repeat (4) cyc();
    loopback = 1'b0;
    cyc();
`endif

    // Random traffic with occasional mid-stream resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      out_write = ($urandom_range(0, 2) != 0);
      out_data  = 8'($urandom);
      tx_ready  = ($urandom_range(0, 3) == 0);
      if (n > 300) tx_ready = ($urandom_range(0, 3) != 0);
      rx_valid  = 1'($urandom);
      rx_data   = 8'($urandom);
`ifdef MP8_IO_LOOPBACK_EN
      loopback  = ($urandom_range(0, 5) == 0);
`endif
      cyc();
    end

    idle();
`ifdef MP8_IO_LOOPBACK_EN
    loopback = 1'b0;
`endif
    tx_ready = 1'b1;
    repeat (8) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
